// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a ROWS x COLS systolic multiply array: clear, skewed operand feed, accumulate strobes.
// Optional stall cycle counter enabled by defining SYSTOLIC_STALL_CNT_EN.
module systolic_seq_ctrl #(
    parameter int ROWS    = 2,
    parameter int COLS    = 2,
    parameter int K_MAX   = 16,
    parameter int HOP_LAT = 2,
    parameter int PE_LAT  = 4,
    parameter int KW      = $clog2(K_MAX + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [KW-1:0]          i_k_len,
    input  logic                   i_abort,
    input  logic                   i_out_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_arr_clr,
    output logic                   o_arr_en,
    output logic [ROWS*KW-1:0]     o_a_idx,
    output logic [ROWS-1:0]        o_a_vld,
    output logic [COLS*KW-1:0]     o_b_idx,
    output logic [COLS-1:0]        o_b_vld,
    output logic [ROWS*COLS-1:0]   o_pe_acc_en,
    output logic [15:0]            o_stall_cnt
);
    localparam int SKEW  = (ROWS + COLS - 2) * HOP_LAT;
    localparam int T_MAX = K_MAX - 1 + PE_LAT + SKEW;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    state_t                 r_state, w_state;
    logic [TW-1:0]          r_t, w_t;
    logic [KW-1:0]          r_k, w_k;
    logic                   r_busy, w_busy, r_done, w_done, r_err, w_err;
    logic                   r_arr_clr, w_arr_clr, r_arr_en, w_arr_en;
    logic [ROWS*KW-1:0]     r_a_idx, w_a_idx;
    logic [ROWS-1:0]        r_a_vld, w_a_vld;
    logic [COLS*KW-1:0]     r_b_idx, w_b_idx;
    logic [COLS-1:0]        r_b_vld, w_b_vld;
    logic [ROWS*COLS-1:0]   r_acc, w_acc;
    logic                   w_feed;
    logic [31:0]            w_step, w_k32, w_t_end;

    always_comb begin
        w_state   = r_state;
        w_t       = r_t;
        w_k       = r_k;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_arr_clr = 1'b0;
        w_arr_en  = 1'b0;
        w_a_idx   = '0;
        w_a_vld   = '0;
        w_b_idx   = '0;
        w_b_vld   = '0;
        w_acc     = '0;
        w_feed    = 1'b0;
        w_step    = '0;
        w_k32     = 32'(r_k);
        w_t_end   = w_k32 + 32'(PE_LAT + SKEW - 1);

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_k_len != '0 && 32'(i_k_len) <= 32'(K_MAX)) begin
                        w_state   = S_CLEAR;
                        w_k       = i_k_len;
                        w_arr_clr = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (i_abort) begin
                    w_state   = S_IDLE;
                    w_arr_clr = 1'b1;
                end else begin
                    w_state = S_RUN;
                    w_t     = '0;
                    w_feed  = 1'b1;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state   = S_IDLE;
                    w_arr_clr = 1'b1;
                end else if (r_arr_en && 32'(r_t) == w_t_end) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_t    = r_t + TW'(r_arr_en);
                    w_feed = 1'b1;
                end
            end
            default: begin
                w_state   = S_IDLE;
                w_arr_clr = i_abort;
            end
        endcase

        // Outputs for the next RUN cycle; a held step reproduces the same feed values.
        if (w_feed) begin
            w_arr_en = i_out_ready;
            w_step   = 32'(w_t);
            for (int r = 0; r < ROWS; r++) begin
                if (w_step >= 32'(r * HOP_LAT) && w_step < 32'(r * HOP_LAT) + w_k32) begin
                    w_a_vld[r]           = 1'b1;
                    w_a_idx[r*KW +: KW]  = KW'(w_step - 32'(r * HOP_LAT));
                end
            end
            for (int c = 0; c < COLS; c++) begin
                if (w_step >= 32'(c * HOP_LAT) && w_step < 32'(c * HOP_LAT) + w_k32) begin
                    w_b_vld[c]           = 1'b1;
                    w_b_idx[c*KW +: KW]  = KW'(w_step - 32'(c * HOP_LAT));
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (w_step >= 32'(PE_LAT + (r + c) * HOP_LAT) &&
                        w_step <  32'(PE_LAT + (r + c) * HOP_LAT) + w_k32)
                        w_acc[r*COLS + c] = i_out_ready;
                end
            end
        end

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_arr_clr <= 1'b0;
            r_arr_en  <= 1'b0;
            r_a_idx   <= '0;
            r_a_vld   <= '0;
            r_b_idx   <= '0;
            r_b_vld   <= '0;
            r_acc     <= '0;
        end else begin
            r_state   <= w_state;
            r_t       <= w_t;
            r_k       <= w_k;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
            r_arr_clr <= w_arr_clr;
            r_arr_en  <= w_arr_en;
            r_a_idx   <= w_a_idx;
            r_a_vld   <= w_a_vld;
            r_b_idx   <= w_b_idx;
            r_b_vld   <= w_b_vld;
            r_acc     <= w_acc;
        end
    end

`ifdef SYSTOLIC_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_stall_cnt <= '0;
        else if (r_state == S_IDLE && w_state == S_CLEAR)
            r_stall_cnt <= '0;
        else if (r_state == S_RUN && !i_out_ready && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_arr_clr   = r_arr_clr;
    assign o_arr_en    = r_arr_en;
    assign o_a_idx     = r_a_idx;
    assign o_a_vld     = r_a_vld;
    assign o_b_idx     = r_b_idx;
    assign o_b_vld     = r_b_vld;
    assign o_pe_acc_en = r_acc;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: start-handling vector table plus jobs checked against a step-count model.
module tb_systolic_seq_ctrl;
    localparam int KW = 5;
    localparam int H  = 2;
    localparam int PL = 4;

    logic            clk, rst, start, abort, out_ready;
    logic [KW-1:0]   k_len;
    logic            busy, done, err, arr_clr, arr_en;
    logic [2*KW-1:0] a_idx, b_idx;
    logic [1:0]      a_vld, b_vld;
    logic [3:0]      pe_acc_en;
    logic [15:0]     stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    systolic_seq_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_k_len(k_len), .i_abort(abort),
        .i_out_ready(out_ready), .o_busy(busy), .o_done(done), .o_err(err),
        .o_arr_clr(arr_clr), .o_arr_en(arr_en), .o_a_idx(a_idx), .o_a_vld(a_vld),
        .o_b_idx(b_idx), .o_b_vld(b_vld), .o_pe_acc_en(pe_acc_en), .o_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_zero"}, {busy, done, err, arr_clr, arr_en, a_idx, a_vld, b_idx, b_vld,
                              pe_acc_en, stall_cnt}, 64'd0);
    endtask

    // Skewed feed / strobe windows straight from the step count t and k.
    task automatic expect_feed(input int t, input int k, input logic en,
                               output logic [1:0] av, output logic [2*KW-1:0] ai,
                               output logic [1:0] bv, output logic [2*KW-1:0] bi,
                               output logic [3:0] acc);
        int s;
        av = '0; ai = '0; bv = '0; bi = '0; acc = '0;
        for (int r = 0; r < 2; r++) begin
            s = t - r * H;
            if (s >= 0 && s < k) begin
                av[r] = 1'b1; ai[r*KW +: KW] = KW'(s);
                bv[r] = 1'b1; bi[r*KW +: KW] = KW'(s);
            end
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                s = t - PL - (r + c) * H;
                acc[r*2 + c] = en && s >= 0 && s < k;
            end
    endtask

    // mode 0: always ready, 1: three stall cycles starting where t==5, 2: random ready.
    task automatic run_job(input int k, input int mode, input int abort_t, output int done_cyc);
        int n_en, c, stalls, stall_left, t_end, t;
        logic rdy, rdy_prev, exp_en, ab, finished, aborted, stall_used;
        logic [1:0] av, bv;
        logic [2*KW-1:0] ai, bi;
        logic [3:0] acc;
        int pulses[4];
        n_en = 0; stalls = 0; stall_left = 0; stall_used = 0;
        finished = 0; aborted = 0; done_cyc = -1;
        t_end = k - 1 + PL + 2 * H;
        for (int i = 0; i < 4; i++) pulses[i] = 0;

        start = 1'b1; k_len = KW'(k); out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_state", {busy, arr_clr, arr_en, done}, {1'b1, 1'b1, 1'b0, 1'b0});
        rdy = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        out_ready = rdy; rdy_prev = rdy;
        tick();
        c = 2;
        for (int g = 0; g < 400; g++) begin
            if (n_en == t_end + 1) begin
                chk("done_cycle", {done, busy, arr_en, arr_clr, pe_acc_en},
                    {1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
                done_cyc = c; finished = 1;
                break;
            end
            t = n_en; exp_en = rdy_prev;
            expect_feed(t, k, exp_en, av, ai, bv, bi, acc);
            chk("run_ctl", {busy, done, arr_clr, arr_en}, {1'b1, 1'b0, 1'b0, exp_en});
            chk("run_vld", {a_vld, b_vld}, {av, bv});
            chk("run_idx", {a_idx, b_idx}, {ai, bi});
            chk("run_acc", pe_acc_en, acc);
            for (int i = 0; i < 4; i++) pulses[i] += int'(pe_acc_en[i]);
            ab = (abort_t >= 0 && t == abort_t);
            if (mode == 1) begin
                if (t == 5 && !stall_used) begin stall_used = 1; stall_left = 3; end
                rdy = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else if (mode == 2) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            if (!rdy) stalls++;
            abort = ab; out_ready = rdy;
            tick();
            c++;
            abort = 1'b0;
            if (ab) begin
                chk("abort_next", {busy, arr_clr, done, arr_en}, {1'b0, 1'b1, 1'b0, 1'b0});
                aborted = 1;
                break;
            end
            if (exp_en) n_en++;
            rdy_prev = rdy;
        end
        out_ready = 1'b1;
        if (!finished && !aborted) begin
            n_chk++; n_err++;
            $display("FAIL job_timeout: k=%0d no done within budget", k);
        end
        if (finished) begin
            for (int i = 0; i < 4; i++) chk("acc_pulses", 64'(pulses[i]), 64'(k));
            tick();
            chk("after_done", {busy, done}, 2'b00);
`ifdef SYSTOLIC_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, 64'(stalls));
`else
            chk("stall_cnt", stall_cnt, 64'd0);
`endif
        end
    endtask

    typedef struct {
        logic        start;
        logic [4:0]  k;
        logic        exp_err;
        logic        exp_acc;
    } vec_t;

    vec_t vecs[6];
    int   dc;
    int   rk;

    initial begin
        vecs[0] = '{1'b1, 5'd0,  1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd17, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 5'd7,  1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd31, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 5'd16, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 5'd1,  1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; k_len = '0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk_all_zero("idle");

        for (int i = 0; i < 6; i++) begin
            start = vecs[i].start; k_len = vecs[i].k;
            tick();
            start = 1'b0;
            chk("vec_err", err, vecs[i].exp_err);
            chk("vec_accept", {busy, arr_clr, arr_en}, {vecs[i].exp_acc, vecs[i].exp_acc, 1'b0});
            if (vecs[i].exp_acc) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("vec_abort_clear", {busy, arr_clr, arr_en, done}, 4'b0100);
            end
            tick();
            chk("vec_quiet", {busy, err, arr_en}, 3'b000);
        end

        run_job(3, 0, -1, dc);
        chk("nominal_done_cyc", 64'(dc), 64'd13);
        run_job(3, 1, -1, dc);
        chk("stall_done_cyc", 64'(dc), 64'd16);
        run_job(3, 0, 6, dc);
        run_job(2, 0, -1, dc);
        chk("restart_done_cyc", 64'(dc), 64'd12);
        run_job(16, 0, -1, dc);
        chk("kmax_done_cyc", 64'(dc), 64'(16 - 1 + PL + 2 * H + 3));
        for (int j = 0; j < 6; j++) begin
            rk = $urandom_range(1, 16);
            run_job(rk, 2, (j == 3) ? 2 : -1, dc);
        end
        run_job(1, 2, -1, dc);

        start = 1'b1; k_len = 5'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_reset_busy", {busy, arr_en}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("post_reset");
        run_job(4, 0, -1, dc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
